// File: rtl/neuron_layer_sequencer.sv
// Sequencer for one fully-parallel neuron layer: accept a vector, pulse run,
// wait the fixed neuron latency, capture outputs, then find the signed argmax.
module neuron_layer_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_INPUTS     = 4,
  parameter int NUM_NEURONS    = 3,
  parameter int NEURON_LATENCY = 7,
  localparam int CW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
  output logic                              neuron_en,
  output logic                              neuron_run,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]  neuron_x,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]                     out_class,
  output logic                              busy
);

  localparam int CNT_W = $clog2(NEURON_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NEURON_LATENCY - 1);
  localparam logic [CW-1:0]    LAST_IDX = CW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ARGMAX, S_OUTPUT} state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]                  cnt_reg;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]  x_reg;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] data_reg;
  logic signed [DATA_WIDTH-1:0]      max_reg;
  logic [CW-1:0]                     class_reg;
  logic [CW-1:0]                     idx_reg;
  logic                              en_reg;

  logic accept, capture, step;

  // Signed element views of the captured outputs, indexed by the compare pointer.
  logic signed [DATA_WIDTH-1:0] elem [NUM_NEURONS];
  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_elem
      assign elem[gi] = data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    step       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = S_START;
        end
      end
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = (NUM_NEURONS == 1) ? S_OUTPUT : S_ARGMAX;
        end
      end
      S_ARGMAX: begin
        step = 1'b1;
        if (idx_reg == LAST_IDX) state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg    <= 1'b0;
      cnt_reg   <= '0;
      x_reg     <= '0;
      data_reg  <= '0;
      max_reg   <= '0;
      class_reg <= '0;
      idx_reg   <= '0;
    end else begin
      en_reg <= 1'b1;
      if (accept) x_reg <= in_data;
      // Counter loaded on the run edge so it reaches zero on the capture edge.
      if (state_reg == S_START)
        cnt_reg <= CNT_LOAD;
      else if (state_reg == S_WAIT && cnt_reg != '0)
        cnt_reg <= cnt_reg - CNT_W'(1);
      if (capture) begin
        data_reg  <= neuron_y;
        max_reg   <= neuron_y[DATA_WIDTH-1:0];
        class_reg <= '0;
        idx_reg   <= CW'(1);
      end else if (step) begin
        if (elem[idx_reg] > max_reg) begin
          max_reg   <= elem[idx_reg];
          class_reg <= idx_reg;
        end
        idx_reg <= idx_reg + CW'(1);
      end
    end
  end

  assign in_ready   = (state_reg == S_IDLE) && !rst;
  assign neuron_en  = en_reg;
  assign neuron_run = (state_reg == S_START);
  assign neuron_x   = x_reg;
  assign out_valid  = (state_reg == S_OUTPUT);
  assign out_data   = data_reg;
  assign out_class  = class_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: fixed-latency stub neurons, directed and
// random vectors checked against a plain argmax model.
module tb_neuron_layer_sequencer;
  localparam int DW = 8;
  localparam int NI = 4;
  localparam int NN = 3;
  localparam int L  = 7;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, neuron_en, neuron_run, out_valid, out_ready, busy;
  logic [NI*DW-1:0] in_data, neuron_x;
  logic [NN*DW-1:0] neuron_y, out_data;
  logic [CW-1:0]    out_class;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neuron_layer_sequencer #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .NEURON_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .neuron_en(neuron_en), .neuron_run(neuron_run), .neuron_x(neuron_x),
    .neuron_y(neuron_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_class(out_class), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub neurons: result is valid only in the cycle before the L-th edge after run.
  logic [NN*DW-1:0] y_q[$];
  logic [NN*DW-1:0] stub_y;
  int age;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age    <= -1;
      stub_y <= '0;
    end else if (neuron_run) begin
      age    <= 0;
      stub_y <= (y_q.size() > 0) ? y_q.pop_front() : '0;
    end else if (age >= 0) begin
      age <= age + 1;
    end
  end
  assign neuron_y = (age == L - 1) ? stub_y : (stub_y ^ 24'hA53C5A);

  int run_cnt = 0;
  int acc_cyc[$];
  logic [CW+NN*DW-1:0] obs_q[$];
  always @(posedge clk) begin
    if (!rst) begin
      if (neuron_run) run_cnt <= run_cnt + 1;
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) obs_q.push_back({out_class, out_data});
    end
  end

  function automatic logic [CW-1:0] ref_class(logic [NN*DW-1:0] y);
    int best = 0;
    for (int j = 1; j < NN; j++)
      if ($signed(y[j*DW +: DW]) > $signed(y[best*DW +: DW])) best = j;
    return CW'(best);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(logic [NI*DW-1:0] x, logic [NN*DW-1:0] y, int bp);
    int e, n, runs0;
    y_q.push_back(y);
    @(negedge clk);
    in_data  = x;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    runs0 = run_cnt;
    @(negedge clk);
    e = cyc;
    in_valid = 1'b0;
    chk("run_pulse", 32'(neuron_run), 32'd1);
    chk("x_latched", neuron_x, x);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      in_data  = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      chk("x_hold", neuron_x, x);
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc - e), 32'(L + NN));
    chk("out_data", 32'(out_data), 32'(y));
    chk("out_class", 32'(out_class), 32'(ref_class(y)));
    chk("run_count", 32'(run_cnt - runs0), 32'd1);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(y));
      chk("bp_class", 32'(out_class), 32'(ref_class(y)));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_idle", 32'(busy), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    $display("vector x=%h y=%h class=%0d bp=%0d", x, y, ref_class(y), bp);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_en"}, 32'(neuron_en), 32'd0);
    chk({tag, "_run"}, 32'(neuron_run), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_x"}, neuron_x, 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_class"}, 32'(out_class), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int n, obs0, acc0, runs0;
    logic [NN*DW-1:0] ys[5];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_en", 32'(neuron_en), 32'd0);
    @(negedge clk);
    chk("en_after_edge", 32'(neuron_en), 32'd1);

    send(32'h04030201, {8'd2, 8'd9, 8'd5}, 0);
    send(32'h11223344, {8'hFF, 8'hFF, 8'hFD}, 0);
    send(32'h55667788, {8'hF8, 8'hF8, 8'hF8}, 0);
    send(32'h99AABBCC, {8'h00, 8'h7F, 8'h80}, 0);
    send(32'h0108F010, {8'd2, 8'd9, 8'd5}, 5);
    for (int k = 0; k < 8; k++) begin
      r = $urandom;
      send($urandom, r[NN*DW-1:0], $urandom_range(0, 3));
    end

    // Abort three cycles after the run pulse.
    r = $urandom;
    y_q.push_back(r[NN*DW-1:0]);
    @(negedge clk);
    in_data = 32'hDEADBEEF; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_run", 32'(neuron_run), 32'd1);
    repeat (3) @(negedge clk);
    obs0 = obs_q.size();
    rst = 1'b1;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    repeat (15) begin @(negedge clk); if (out_valid) n++; end
    out_ready = 1'b0;
    chk("abort_no_valid", 32'(n), 32'd0);
    chk("abort_no_output", 32'(obs_q.size() - obs0), 32'd0);
    $display("abort during wait");
    send(32'h0A0B0C0D, {8'h80, 8'h81, 8'h7E}, 1);

    // Back-to-back streaming with both handshakes held high.
    y_q.delete();
    for (int k = 0; k < 5; k++) begin
      r = $urandom;
      ys[k] = r[NN*DW-1:0];
      y_q.push_back(ys[k]);
    end
    obs0 = obs_q.size(); acc0 = acc_cyc.size(); runs0 = run_cnt;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (obs_q.size() - obs0 < 5 && n < 200) begin
      in_data = $urandom;
      @(negedge clk);
      n++;
      if (acc_cyc.size() - acc0 >= 5) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_timeout", 32'(n < 200), 32'd1);
    chk("b2b_accepts", 32'(acc_cyc.size() - acc0), 32'd5);
    chk("b2b_runs", 32'(run_cnt - runs0), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k > 0 && acc0 + k < acc_cyc.size())
        chk("b2b_period", 32'(acc_cyc[acc0+k] - acc_cyc[acc0+k-1]), 32'(L + NN + 2));
      if (obs0 + k < obs_q.size()) begin
        chk("b2b_result", 32'(obs_q[obs0+k]), 32'({ref_class(ys[k]), ys[k]}));
        $display("stream %0d y=%h class=%0d", k, ys[k], ref_class(ys[k]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
